// File: rtl/cache_requester_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_requester_pkg
//  Description : Shared definitions for the cache requester: FSM state
//                encoding, default data/address widths, statistics counter
//                width and memory timeout defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_requester_pkg;

  // Default interface widths
  localparam int c_LINE_SIZE   = 32;
  localparam int c_ADDR_WIDTH  = 8;

  // Backing-memory wait limit; the timeout counter is 8 bits wide
  localparam int c_MEM_TIMEOUT = 255;
  localparam int c_TMO_WIDTH   = 8;

  // Hit/miss statistics counter width
  localparam int c_CNT_WIDTH   = 16;

  // FSM state encoding
  localparam int c_STATE_W = 3;
  typedef logic [c_STATE_W-1:0] state_t;

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_ISSUE    = 3'd1;
  localparam logic [2:0] c_CHECK    = 3'd2;
  localparam logic [2:0] c_MEM_WAIT = 3'd3;
  localparam logic [2:0] c_FILL     = 3'd4;
  localparam logic [2:0] c_RESP     = 3'd5;

  // True in the states that are allowed to touch the cache port
  function automatic logic is_cache_state(input state_t st);
    return (st == c_ISSUE) || (st == c_FILL);
  endfunction

endpackage : cache_requester_pkg
`default_nettype wire

// File: rtl/cache_requester_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that stops at its all-ones value.
//  Ports       : clk     - clock
//                rst_n   - asynchronous active-low reset (count -> 0)
//                i_inc   - increment request for this cycle
//                o_count - current count value
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_count;
  logic             w_sat;

  assign w_sat = (r_count == c_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && !w_sat) begin
      r_count <= r_count + c_ONE;
    end
  end

  assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/cache_requester.sv
`default_nettype none
// ============================================================================
//  Module      : cache_requester
//  Description : Single-outstanding command front end for a cache controller.
//                Reads probe the cache, and on a miss fetch the line from
//                backing memory, fill the cache and return the data. Writes go
//                straight to the cache. Read hits/misses are counted.
//  Ports       : clk, rst_n                  - clock, async active-low reset
//                i_cmd_* / o_cmd_ready       - command channel (valid/ready)
//                o_rsp_* / i_rsp_ready       - response channel (valid/ready)
//                o_cache_* / i_cache_*       - cache controller port; read
//                                              result arrives one cycle after
//                                              o_cache_rd_en
//                o_mem_req/o_mem_addr        - line fetch request, held to ack
//                i_mem_ack/i_mem_rdata       - one-cycle ack with fill data
//                o_hit_cnt/o_miss_cnt        - saturating read statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_requester
  import cache_requester_pkg::*;
#(
  parameter int LINE_SIZE   = c_LINE_SIZE,
  parameter int ADDR_WIDTH  = c_ADDR_WIDTH,
  parameter int MEM_TIMEOUT = c_MEM_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // command channel
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic                   i_cmd_wr,
  input  logic [ADDR_WIDTH-1:0]  i_cmd_addr,
  input  logic [LINE_SIZE-1:0]   i_cmd_wdata,
  // response channel
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [LINE_SIZE-1:0]   o_rsp_data,
  output logic                   o_rsp_hit,
  output logic                   o_rsp_err,
  // cache controller port
  output logic [ADDR_WIDTH-1:0]  o_cache_addr,
  output logic                   o_cache_wr_en,
  output logic                   o_cache_rd_en,
  output logic [LINE_SIZE-1:0]   o_cache_data_in,
  input  logic [LINE_SIZE-1:0]   i_cache_data_out,
  input  logic                   i_cache_hit,
  // backing memory
  output logic                   o_mem_req,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  input  logic                   i_mem_ack,
  input  logic [LINE_SIZE-1:0]   i_mem_rdata,
  // statistics
  output logic [c_CNT_WIDTH-1:0] o_hit_cnt,
  output logic [c_CNT_WIDTH-1:0] o_miss_cnt
);

  // Last MEM_WAIT cycle index; MEM_WAIT lasts exactly MEM_TIMEOUT cycles
  // when no ack arrives (MEM_TIMEOUT is expected to be 1..255).
  localparam logic [c_TMO_WIDTH-1:0] c_TMO_LAST = c_TMO_WIDTH'(MEM_TIMEOUT - 1);
  localparam logic [c_TMO_WIDTH-1:0] c_TMO_ONE  = {{(c_TMO_WIDTH-1){1'b0}}, 1'b1};

  state_t                  r_state;
  logic                    r_wr;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LINE_SIZE-1:0]    r_wdata;
  logic [LINE_SIZE-1:0]    r_fill;
  logic [c_TMO_WIDTH-1:0]  r_tmo;
  logic [LINE_SIZE-1:0]    r_rsp_data;
  logic                    r_rsp_hit;
  logic                    r_rsp_err;

  logic                    w_hit_inc;
  logic                    w_miss_inc;
  logic                    w_cache_op;

  // --------------------------------------------------------------------------
  // Main FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_fill     <= '0;
      r_tmo      <= '0;
      r_rsp_data <= '0;
      r_rsp_hit  <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (i_cmd_valid) begin
            r_wr    <= i_cmd_wr;
            r_addr  <= i_cmd_addr;
            r_wdata <= i_cmd_wdata;
            r_state <= c_ISSUE;
          end
        end

        c_ISSUE: begin
          if (r_wr) begin
            // Writes complete as soon as the cache write is issued
            r_rsp_data <= r_wdata;
            r_rsp_hit  <= 1'b0;
            r_rsp_err  <= 1'b0;
            r_state    <= c_RESP;
          end else begin
            r_state    <= c_CHECK;
          end
        end

        c_CHECK: begin
          // Cache result is registered, so it is valid in the cycle after ISSUE
          if (i_cache_hit) begin
            r_rsp_data <= i_cache_data_out;
            r_rsp_hit  <= 1'b1;
            r_rsp_err  <= 1'b0;
            r_state    <= c_RESP;
          end else begin
            r_tmo      <= '0;
            r_state    <= c_MEM_WAIT;
          end
        end

        c_MEM_WAIT: begin
          // An ack on the final allowed cycle still wins over the timeout
          if (i_mem_ack) begin
            r_fill  <= i_mem_rdata;
            r_state <= c_FILL;
          end else if (r_tmo == c_TMO_LAST) begin
            r_rsp_data <= '0;
            r_rsp_hit  <= 1'b0;
            r_rsp_err  <= 1'b1;
            r_state    <= c_RESP;
          end else begin
            r_tmo <= r_tmo + c_TMO_ONE;
          end
        end

        c_FILL: begin
          r_rsp_data <= r_fill;
          r_rsp_hit  <= 1'b0;
          r_rsp_err  <= 1'b0;
          r_state    <= c_RESP;
        end

        c_RESP: begin
          if (i_rsp_ready) begin
            r_state <= c_IDLE;
          end
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs decoded from state. Decoding from the asynchronously reset state
  // register makes mem_req and the cache strobes drop as soon as rst_n falls.
  // --------------------------------------------------------------------------
  assign w_cache_op      = is_cache_state(r_state);

  assign o_cmd_ready     = (r_state == c_IDLE);
  assign o_rsp_valid     = (r_state == c_RESP);
  assign o_rsp_data      = r_rsp_data;
  assign o_rsp_hit       = r_rsp_hit;
  assign o_rsp_err       = r_rsp_err;

  assign o_cache_rd_en   = (r_state == c_ISSUE) && !r_wr;
  assign o_cache_wr_en   = ((r_state == c_ISSUE) && r_wr) || (r_state == c_FILL);
  assign o_cache_addr    = w_cache_op ? r_addr : '0;
  assign o_cache_data_in = (r_state == c_FILL)             ? r_fill  :
                           ((r_state == c_ISSUE) && r_wr)  ? r_wdata : '0;

  assign o_mem_req       = (r_state == c_MEM_WAIT);
  assign o_mem_addr      = o_mem_req ? r_addr : '0;

  // --------------------------------------------------------------------------
  // Read statistics, resolved in CHECK
  // --------------------------------------------------------------------------
  assign w_hit_inc  = (r_state == c_CHECK) &&  i_cache_hit;
  assign w_miss_inc = (r_state == c_CHECK) && !i_cache_hit;

  sat_counter #(
    .WIDTH (c_CNT_WIDTH)
  ) u_hit_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_hit_inc),
    .o_count (o_hit_cnt)
  );

  sat_counter #(
    .WIDTH (c_CNT_WIDTH)
  ) u_miss_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_miss_inc),
    .o_count (o_miss_cnt)
  );

endmodule : cache_requester
`default_nettype wire

// File: tb/tb_cache_requester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_requester
//  Description : Directed self-checking bench for cache_requester with a
//                behavioural cache controller and backing-memory driver.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_requester;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_hit, rsp_err;
  logic [7:0]  cache_addr;
  logic        cache_wr_en, cache_rd_en;
  logic [31:0] cache_data_in, cache_data_out;
  logic        cache_hit;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [15:0] hit_cnt, miss_cnt;

  logic        sat_inc;
  logic [3:0]  sat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cache_requester dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_cmd_valid      (cmd_valid),
    .o_cmd_ready      (cmd_ready),
    .i_cmd_wr         (cmd_wr),
    .i_cmd_addr       (cmd_addr),
    .i_cmd_wdata      (cmd_wdata),
    .o_rsp_valid      (rsp_valid),
    .i_rsp_ready      (rsp_ready),
    .o_rsp_data       (rsp_data),
    .o_rsp_hit        (rsp_hit),
    .o_rsp_err        (rsp_err),
    .o_cache_addr     (cache_addr),
    .o_cache_wr_en    (cache_wr_en),
    .o_cache_rd_en    (cache_rd_en),
    .o_cache_data_in  (cache_data_in),
    .i_cache_data_out (cache_data_out),
    .i_cache_hit      (cache_hit),
    .o_mem_req        (mem_req),
    .o_mem_addr       (mem_addr),
    .i_mem_ack        (mem_ack),
    .i_mem_rdata      (mem_rdata),
    .o_hit_cnt        (hit_cnt),
    .o_miss_cnt       (miss_cnt)
  );

  // Small-width instance to reach saturation in a few cycles
  sat_counter #(.WIDTH(4)) u_sat (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (sat_inc),
    .o_count (sat_cnt)
  );

  // Behavioural cache controller: registered read result, valid bit per line
  logic [31:0] cmem [256];
  logic        cval [256];
  int          wr_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_hit      <= 1'b0;
      cache_data_out <= 32'h0;
      wr_cnt         <= 0;
      for (int i = 0; i < 256; i++) cval[i] <= 1'b0;
    end else begin
      if (cache_rd_en) begin
        cache_data_out <= cmem[cache_addr];
        cache_hit      <= cval[cache_addr];
      end
      if (cache_wr_en) begin
        cmem[cache_addr] <= cache_data_in;
        cval[cache_addr] <= 1'b1;
        wr_cnt           <= wr_cnt + 1;
      end
    end
  end

  // Read and write strobes must never coincide
  always @(negedge clk) begin
    if (rst_n) chk_eq("rd_wr_excl", 32'(cache_rd_en & cache_wr_en), 32'd0);
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Values seen in the first cycle after handshake/ack (ISSUE or FILL)
  logic       s_rd, s_wr;
  logic [7:0] s_addr;
  logic [31:0] s_din;

  task automatic send_cmd(input logic wr, input logic [7:0] addr, input logic [31:0] data);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = data;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_eq("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Counts falling edges from the reference edge until rsp_valid is seen
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        s_rd = cache_rd_en; s_wr = cache_wr_en; s_addr = cache_addr; s_din = cache_data_in;
      end
    end while (!rsp_valid && lat < 400);
    chk_eq("rsp_valid_seen", 32'(rsp_valid), 32'd1);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk_eq("idle_after_rsp", 32'({cmd_ready, rsp_valid}), 32'b10);
  endtask

  task automatic wait_mem_req();
    int n = 0;
    while (!mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_eq("mem_req_seen", 32'(mem_req), 32'd1);
  endtask

  int lat, wc0, hi_cycles;
  logic [31:0] hold_data;
  logic        stray_rsp;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'h0; cmd_wdata = 32'h0;
    rsp_ready = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0; sat_inc = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk_eq("rst_rsp_flags", 32'({rsp_hit, rsp_err}), 32'd0);
    chk_eq("rst_rsp_data", rsp_data, 32'h0);
    chk_eq("rst_mem_req", 32'({mem_req, mem_addr}), 32'd0);
    chk_eq("rst_cache_en", 32'({cache_rd_en, cache_wr_en}), 32'd0);
    chk_eq("rst_cache_addr", 32'(cache_addr), 32'd0);
    chk_eq("rst_counters", {hit_cnt, miss_cnt}, 32'd0);

    // Stray mem_ack in IDLE is ignored
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    chk_eq("stray_ack_idle", 32'({cmd_ready, rsp_valid, mem_req}), 32'b100);

    // Write 0x10 = DEADBEEF (also preloads the line)
    send_cmd(1'b1, 8'h10, 32'hDEADBEEF);
    wait_rsp(lat);
    chk_eq("wr_latency", 32'(lat), 32'd2);
    chk_eq("wr_issue_en", 32'({s_rd, s_wr}), 32'b01);
    chk_eq("wr_issue_addr", 32'(s_addr), 32'h10);
    chk_eq("wr_issue_din", s_din, 32'hDEADBEEF);
    chk_eq("wr_rsp_data", rsp_data, 32'hDEADBEEF);
    chk_eq("wr_rsp_flags", 32'({rsp_hit, rsp_err}), 32'd0);
    finish_rsp();

    // Read hit 0x10
    send_cmd(1'b0, 8'h10, 32'h0);
    wait_rsp(lat);
    chk_eq("hit_latency", 32'(lat), 32'd3);
    chk_eq("hit_issue_en", 32'({s_rd, s_wr}), 32'b10);
    chk_eq("hit_issue_addr", 32'(s_addr), 32'h10);
    chk_eq("hit_rsp_data", rsp_data, 32'hDEADBEEF);
    chk_eq("hit_rsp_flags", 32'({rsp_hit, rsp_err}), 32'b10);
    chk_eq("hit_cnt_1", 32'(hit_cnt), 32'd1);
    chk_eq("miss_cnt_0", 32'(miss_cnt), 32'd0);
    finish_rsp();

    // Read miss 0x22, ack five cycles into MEM_WAIT
    wc0 = wr_cnt;
    send_cmd(1'b0, 8'h22, 32'h0);
    wait_mem_req();
    chk_eq("miss_mem_addr", 32'(mem_addr), 32'h22);
    chk_eq("miss_cnt_1", 32'(miss_cnt), 32'd1);
    repeat (4) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk);
    #1 mem_ack = 1'b0; mem_rdata = 32'h0;
    wait_rsp(lat);
    chk_eq("miss_ack_latency", 32'(lat), 32'd2);
    chk_eq("fill_en", 32'({s_rd, s_wr}), 32'b01);
    chk_eq("fill_addr", 32'(s_addr), 32'h22);
    chk_eq("fill_din", s_din, 32'h12345678);
    chk_eq("miss_rsp_data", rsp_data, 32'h12345678);
    chk_eq("miss_rsp_flags", 32'({rsp_hit, rsp_err, mem_req}), 32'd0);
    chk_eq("fill_wr_count", 32'(wr_cnt - wc0), 32'd1);
    finish_rsp();

    // Re-read 0x22 now hits
    send_cmd(1'b0, 8'h22, 32'h0);
    wait_rsp(lat);
    chk_eq("rehit_latency", 32'(lat), 32'd3);
    chk_eq("rehit_rsp_data", rsp_data, 32'h12345678);
    chk_eq("rehit_flags", 32'({rsp_hit, rsp_err}), 32'b10);
    chk_eq("hit_cnt_2", 32'(hit_cnt), 32'd2);
    finish_rsp();

    // Timeout on 0x33
    send_cmd(1'b0, 8'h33, 32'h0);
    wait_mem_req();
    hi_cycles = 0;
    while (mem_req && hi_cycles < 400) begin
      hi_cycles++;
      @(negedge clk);
    end
    chk_eq("tmo_req_cycles", 32'(hi_cycles), 32'd255);
    chk_eq("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
    chk_eq("tmo_rsp_data", rsp_data, 32'h0);
    chk_eq("tmo_rsp_flags", 32'({rsp_hit, rsp_err}), 32'b01);
    chk_eq("miss_cnt_2", 32'(miss_cnt), 32'd2);
    finish_rsp();

    // Backpressure on a write response, with a competing command pending
    send_cmd(1'b1, 8'h44, 32'hA5A5A5A5);
    wait_rsp(lat);
    hold_data = rsp_data;
    chk_eq("bp_first_data", hold_data, 32'hA5A5A5A5);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h10;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_eq("bp_valid_held", 32'(rsp_valid), 32'd1);
      chk_eq("bp_data_held", rsp_data, hold_data);
      chk_eq("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    finish_rsp();

    // Reset while in MEM_WAIT
    send_cmd(1'b0, 8'h66, 32'h0);
    wait_mem_req();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk_eq("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk_eq("rst_mid_counters", {hit_cnt, miss_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray_rsp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      stray_rsp = stray_rsp | rsp_valid | mem_req;
    end
    chk_eq("rst_mid_no_rsp", 32'(stray_rsp), 32'd0);
    chk_eq("rst_mid_ready", 32'(cmd_ready), 32'd1);

    // Saturation of the counter sub-module (4-bit instance)
    sat_inc = 1'b1;
    repeat (14) @(negedge clk);
    chk_eq("sat_count_14", 32'(sat_cnt), 32'd14);
    @(negedge clk);
    chk_eq("sat_count_15", 32'(sat_cnt), 32'd15);
    repeat (5) @(negedge clk);
    chk_eq("sat_hold_15", 32'(sat_cnt), 32'd15);
    sat_inc = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_cache_requester
`default_nettype wire
